// File: rtl/edge_stage_sequencer.sv
// Sequencer for the edge-detection pipeline: launches each stage in turn with a
// one-cycle enable, waits for that stage's done rising edge, and times out stuck stages.
module edge_stage_sequencer #(
  parameter int NUM_STAGES = 5,
  parameter int TIMEOUT    = 4096,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [NUM_STAGES-1:0] stage_enable,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            cur_stage,
  output logic [CNT_W-1:0]      total_cycles
);

  localparam int                WCNT_W       = $clog2(TIMEOUT + 1);
  localparam logic [2:0]        LAST_STAGE   = 3'(NUM_STAGES - 1);
  localparam logic [WCNT_W-1:0] TIMEOUT_LAST = WCNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_FINISH,
    S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            cur_stage_q, cur_stage_d;
  logic [WCNT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]      total_q, total_d;
  logic [NUM_STAGES-1:0] done_hist_q, done_hist_d;
  logic [NUM_STAGES-1:0] done_rise;
  logic                  completion;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Only a fresh 0->1 transition of the current stage counts; a level left high
  // from an earlier run, or activity on other stages, must not advance the sequence.
  always_comb begin
    done_rise  = stage_done & ~done_hist_q;
    completion = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (cur_stage_q == 3'(i)) completion = done_rise[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_stage_d = cur_stage_q;
    wait_cnt_d  = wait_cnt_q;
    total_d     = total_q;
    done_hist_d = stage_done;

    if (state_q == S_LAUNCH || state_q == S_WAIT || state_q == S_FINISH) begin
      total_d = sat_inc(total_q);
    end

    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d     = S_LAUNCH;
            cur_stage_d = '0;
            total_d     = '0;
          end
        end
        S_LAUNCH: begin
          wait_cnt_d = '0;
          state_d    = S_WAIT;
        end
        S_WAIT: begin
          // Completion takes precedence over a timeout landing in the same cycle.
          if (completion) begin
            if (cur_stage_q == LAST_STAGE) begin
              state_d = S_FINISH;
            end else begin
              cur_stage_d = cur_stage_q + 3'd1;
              state_d     = S_LAUNCH;
            end
          end else begin
            wait_cnt_d = wait_cnt_q + WCNT_W'(1);
            if (wait_cnt_q >= TIMEOUT_LAST) state_d = S_ERROR;
          end
        end
        S_FINISH: begin
          state_d = S_IDLE;
        end
        S_ERROR: begin
          if (start) begin
            state_d     = S_LAUNCH;
            cur_stage_d = '0;
            total_d     = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cur_stage_q <= '0;
      wait_cnt_q  <= '0;
      total_q     <= '0;
      done_hist_q <= '0;
    end else begin
      state_q     <= state_d;
      cur_stage_q <= cur_stage_d;
      wait_cnt_q  <= wait_cnt_d;
      total_q     <= total_d;
      done_hist_q <= done_hist_d;
    end
  end

  always_comb begin
    stage_enable = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      stage_enable[i] = (state_q == S_LAUNCH) && (cur_stage_q == 3'(i));
    end
  end

  assign busy         = (state_q == S_LAUNCH) || (state_q == S_WAIT);
  assign done         = (state_q == S_FINISH);
  assign error        = (state_q == S_ERROR);
  assign cur_stage    = cur_stage_q;
  assign total_cycles = total_q;

endmodule

// File: tb/tb_edge_stage_sequencer.sv
// Scoreboard bench for edge_stage_sequencer: directed runs queue the expected
// enable/done/error events; a negedge monitor pops and compares them.
module tb_edge_stage_sequencer;
  localparam int NS = 5;
  localparam int TO = 16;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [NS-1:0] stage_done = '0;
  logic [NS-1:0] stage_enable;
  logic          busy, done, error;
  logic [2:0]    cur_stage;
  logic [CW-1:0] total_cycles;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    int            cyc;
    logic [NS-1:0] en;
    logic          dn;
    logic          er;
    logic          bsy;
    logic [2:0]    stg;
    logic [CW-1:0] tot;
  } ev_t;

  ev_t exp_q[$];

  edge_stage_sequencer #(.NUM_STAGES(NS), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .stage_done(stage_done), .stage_enable(stage_enable), .busy(busy),
    .done(done), .error(error), .cur_stage(cur_stage), .total_cycles(total_cycles)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, expv, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic push_ev(input int c, input logic [NS-1:0] en, input logic dn, input logic er,
                         input logic bsy, input logic [2:0] stg, input logic [CW-1:0] tot);
    ev_t e;
    e.cyc = c; e.en = en; e.dn = dn; e.er = er; e.bsy = bsy; e.stg = stg; e.tot = tot;
    exp_q.push_back(e);
  endtask

  task automatic push_en(input int c, input int k, input int tot);
    logic [NS-1:0] one;
    one = 1;
    push_ev(c, one << k, 1'b0, 1'b0, 1'b1, 3'(k), CW'(tot));
  endtask

  task automatic begin_run(output int s);
    start = 1'b1;
    step();
    start = 1'b0;
    s = cyc;
  endtask

  // Stage k raises done one cycle after its enable and drops it at the next enable.
  task automatic fast_stages(input int s, input int n);
    for (int k = 0; k < n; k++) begin
      wait_to(s + 2 * k + 1);
      stage_done[k] = 1'b1;
      wait_to(s + 2 * k + 2);
      stage_done[k] = 1'b0;
    end
  endtask

  // Each stage raises done 3 cycles after its enable: 4 cycles per stage.
  task automatic nominal_run(input bit restart_pulse);
    int s;
    begin_run(s);
    for (int k = 0; k < NS; k++) push_en(s + 4 * k, k, 4 * k);
    push_ev(s + 20, '0, 1'b1, 1'b0, 1'b0, 3'd4, CW'(20));
    for (int r = 0; r <= 20; r++) begin
      if (r % 4 == 3) stage_done[r / 4] = 1'b1;
      if (r % 4 == 0 && r > 0) stage_done[r / 4 - 1] = 1'b0;
      start = restart_pulse && (r == 5);
      step();
    end
    chk("nominal_busy_after", busy, 0);
    chk("nominal_total_after", total_cycles, 21);
    chk("nominal_stage_after", cur_stage, 4);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_enable"}, stage_enable, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_stage"}, cur_stage, 0);
    chk({tag, "_total"}, total_cycles, 0);
  endtask

  initial begin : monitor
    ev_t e;
    logic err_prev;
    err_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (stage_enable != '0 || done || (error && !err_prev)) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_event: cyc %0d en %b done %b err %b stage %0d tot %0d",
                   cyc, stage_enable, done, error, cur_stage, total_cycles);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc == cyc && e.en === stage_enable && e.dn === done && e.er === error &&
              e.bsy === busy && e.stg === cur_stage && e.tot === total_cycles) begin
            n_pass++;
          end else begin
            $display("FAIL event: got cyc %0d en %b dn %b er %b busy %b stg %0d tot %0d, expected cyc %0d en %b dn %b er %b busy %b stg %0d tot %0d",
                     cyc, stage_enable, done, error, busy, cur_stage, total_cycles,
                     e.cyc, e.en, e.dn, e.er, e.bsy, e.stg, e.tot);
          end
        end
      end
      err_prev = error;
    end
  end

  initial begin : stimulus
    int s;
    repeat (3) step();
    check_reset_outputs("reset");
    reset = 1'b1;
    step();

    nominal_run(1'b0);
    step();
    nominal_run(1'b1);

    // Minimum-length run: every stage done one cycle after its enable.
    step();
    begin_run(s);
    for (int k = 0; k < NS; k++) push_en(s + 2 * k, k, 2 * k);
    push_ev(s + 10, '0, 1'b1, 1'b0, 1'b0, 3'd4, CW'(10));
    fast_stages(s, NS);
    wait_to(s + 11);
    chk("min_run_total", total_cycles, 11);

    // Stale done level on stage 0 must not count as completion.
    stage_done[0] = 1'b1;
    repeat (3) step();
    begin_run(s);
    push_en(s, 0, 0);
    push_en(s + 6, 1, 6);
    wait_to(s + 1);
    stage_done[0] = 1'b0;
    wait_to(s + 5);
    stage_done[0] = 1'b1;
    wait_to(s + 6);
    abort = 1'b1;
    step();
    abort = 1'b0;
    stage_done = '0;
    chk("stale_busy", busy, 0);
    chk("stale_total", total_cycles, 7);
    repeat (2) step();
    chk("stale_total_frozen", total_cycles, 7);

    // Stage 2 never completes: error after 16 WAIT cycles, then restart from error.
    step();
    begin_run(s);
    push_en(s, 0, 0);
    push_en(s + 2, 1, 2);
    push_en(s + 4, 2, 4);
    push_ev(s + 21, '0, 1'b0, 1'b1, 1'b0, 3'd2, CW'(21));
    fast_stages(s, 2);
    wait_to(s + 23);
    chk("timeout_error_sticky", error, 1);
    chk("timeout_stage", cur_stage, 2);
    chk("timeout_busy", busy, 0);
    chk("timeout_total", total_cycles, 21);
    start = 1'b1;
    push_en(s + 24, 0, 0);
    step();
    start = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("restart_error_cleared", error, 0);
    chk("restart_abort_busy", busy, 0);

    // Abort in the same cycle as stage 3's done rising edge.
    step();
    begin_run(s);
    for (int k = 0; k < 4; k++) push_en(s + 2 * k, k, 2 * k);
    fast_stages(s, 3);
    wait_to(s + 8);
    stage_done[3] = 1'b1;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_total", total_cycles, 9);
    stage_done = '0;
    repeat (5) step();
    chk("abort_total_frozen", total_cycles, 9);

    // Reset pulse while waiting on stage 4.
    step();
    begin_run(s);
    for (int k = 0; k < NS; k++) push_en(s + 2 * k, k, 2 * k);
    fast_stages(s, 4);
    wait_to(s + 9);
    reset = 1'b0;
    step();
    check_reset_outputs("midrun_reset");
    reset = 1'b1;
    repeat (3) step();

    // Done activity on a non-current stage is ignored.
    begin_run(s);
    push_en(s, 0, 0);
    push_en(s + 7, 1, 7);
    for (int r = 1; r <= 4; r++) begin
      wait_to(s + r);
      stage_done[4] = (r % 2 == 1);
    end
    wait_to(s + 6);
    stage_done[0] = 1'b1;
    step();
    stage_done[0] = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("wrong_stage_busy", busy, 0);

    repeat (5) step();
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
